// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and block geometry for the cache fill controller slice.
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int WORD_BYTES        = 2;
  localparam int BLOCK_OFFSET_BITS = $clog2(WORD_BYTES * WORDS_PER_BLOCK);
  localparam int CNT_W             = $clog2(WORDS_PER_BLOCK);

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Signals between the fill controller, the pipeline/cache arrays and the memory model.
interface cache_fill_ctrl_if #(
  parameter int ADDR_WIDTH = 16
);

  // Handshakes: store_req is held with store_addr/store_data stable until the
  // single-cycle store_ack, and the store is transferred in that ack cycle.
  // mem_enable has no ready: memory takes a request in every cycle it is high
  // and returns reads in issue order, one per memory_data_valid cycle.
  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic                  store_req;
  logic [ADDR_WIDTH-1:0] store_addr;
  logic [15:0]           store_data;
  logic                  memory_data_valid;
  logic [15:0]           memory_data;
  logic                  fsm_busy;
  logic                  store_ack;
  logic                  mem_enable;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_data_in;
  logic                  write_data_array;
  logic                  write_tag_array;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [15:0]           fill_data;

  modport master (
    input  miss_detected, miss_address, store_req, store_addr, store_data,
           memory_data_valid, memory_data,
    output fsm_busy, store_ack, mem_enable, mem_wr, mem_addr, mem_data_in,
           write_data_array, write_tag_array, fill_addr, fill_data
  );

  modport slave (
    output miss_detected, miss_address, store_req, store_addr, store_data,
           memory_data_valid, memory_data,
    input  fsm_busy, store_ack, mem_enable, mem_wr, mem_addr, mem_data_in,
           write_data_array, write_tag_array, fill_addr, fill_data
  );

endinterface

// File: rtl/cache_fill_ctrl_block_word_counter.sv
// Word index within a cache block; wrap flags the increment out of the last word.
module block_word_counter
  import cache_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign wrap = inc && (count == {WIDTH{1'b1}});

endmodule

// File: rtl/cache_fill_ctrl.sv
// Block fill on miss plus write-through stores from IDLE; sole initiator on the memory port.
module cache_fill_ctrl #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK
) (
  input  logic              clk,
  input  logic              rst,
  cache_fill_ctrl_if.master bus,
  output cache_pkg::state_t state_dbg
);

  localparam int CW       = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_BITS = $clog2(cache_pkg::WORD_BYTES * WORDS_PER_BLOCK);
  localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK =
    {{(ADDR_WIDTH-OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};

  cache_pkg::state_t     state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  req_done_q;
  logic [CW-1:0]         req_cnt, rsp_cnt;
  logic                  in_fill, req_inc, rsp_inc, cnt_clr, req_wrap, rsp_wrap;

  // base is block-aligned, so adding the word offset never carries out of the block.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [CW-1:0] idx);
    return base_q + ADDR_WIDTH'({idx, 1'b0});
  endfunction

  assign in_fill   = (state_q == cache_pkg::FILL);
  assign req_inc   = in_fill && !req_done_q;
  assign rsp_inc   = in_fill && bus.memory_data_valid;
  assign cnt_clr   = !in_fill || rsp_wrap;
  assign state_dbg = state_q;

  block_word_counter #(.WIDTH(CW)) u_req_cnt (
    .clk(clk), .rst(rst), .inc(req_inc), .clr(cnt_clr), .count(req_cnt), .wrap(req_wrap)
  );

  block_word_counter #(.WIDTH(CW)) u_rsp_cnt (
    .clk(clk), .rst(rst), .inc(rsp_inc), .clr(cnt_clr), .count(rsp_cnt), .wrap(rsp_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= cache_pkg::IDLE;
      base_q     <= '0;
      req_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!in_fill && bus.miss_detected) begin
        base_q <= bus.miss_address & BLOCK_MASK;
      end
      if (cnt_clr) begin
        req_done_q <= 1'b0;
      end else if (req_wrap) begin
        req_done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    bus.fsm_busy         = 1'b0;
    bus.store_ack        = 1'b0;
    bus.mem_enable       = 1'b0;
    bus.mem_wr           = 1'b0;
    bus.mem_addr         = '0;
    bus.mem_data_in      = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    bus.fill_addr        = '0;
    bus.fill_data        = '0;
    case (state_q)
      cache_pkg::IDLE: begin
        // A miss wins; a concurrent store keeps waiting until the fill is done.
        if (bus.miss_detected) begin
          state_d = cache_pkg::FILL;
        end else if (bus.store_req) begin
          bus.mem_enable  = 1'b1;
          bus.mem_wr      = 1'b1;
          bus.mem_addr    = bus.store_addr;
          bus.mem_data_in = bus.store_data;
          bus.store_ack   = 1'b1;
        end
      end
      cache_pkg::FILL: begin
        bus.fsm_busy = 1'b1;
        if (!req_done_q) begin
          bus.mem_enable = 1'b1;
          bus.mem_addr   = word_addr(req_cnt);
        end
        if (bus.memory_data_valid) begin
          bus.write_data_array = 1'b1;
          bus.fill_addr        = word_addr(rsp_cnt);
          bus.fill_data        = bus.memory_data;
        end
        if (rsp_wrap) begin
          bus.write_tag_array = 1'b1;
          state_d             = cache_pkg::IDLE;
        end
      end
      default: state_d = cache_pkg::IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed and randomized fills/stores checked against a block-level memory model.
module tb_cache_fill_ctrl;
  import cache_pkg::*;

  localparam int AW = 16;

  logic   clk = 1'b0;
  logic   rst;
  state_t state_dbg;
  logic [15:0] seed;
  int n_checks = 0;
  int n_fail   = 0;

  cache_fill_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  cache_fill_ctrl #(.ADDR_WIDTH(AW), .WORDS_PER_BLOCK(WORDS_PER_BLOCK)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory contents: a fixed scramble of the address, keyed per run.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a * 16'h9E37) ^ seed;
  endfunction

  task automatic idle_inputs();
    bus.miss_detected     = 1'b0;
    bus.miss_address      = '0;
    bus.store_req         = 1'b0;
    bus.store_addr        = '0;
    bus.store_data        = '0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = '0;
  endtask

  task automatic outputs_quiet(input string tag);
    check({tag, "_busy"},     bus.fsm_busy, 0);
    check({tag, "_mem_en"},   bus.mem_enable, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_ack"},      bus.store_ack, 0);
    check({tag, "_data_wr"},  bus.write_data_array, 0);
    check({tag, "_tag_wr"},   bus.write_tag_array, 0);
    check({tag, "_fill_adr"}, bus.fill_addr, 0);
  endtask

  // One miss and the whole fill that follows; rst_after>0 resets after that many words.
  task automatic run_fill(input logic [15:0] maddr, input int lat, input int gap_max,
                          input bit with_store, input bit noise, input int rst_after);
    logic [15:0] blk, dat_q[$];
    int          due_q[$];
    int          last_due, n_wr, c, due;
    bit          done, vld, aborted;
    blk = maddr & 16'hFFF0;
    last_due = 0; n_wr = 0; done = 0; aborted = 0;
    @(posedge clk); #1;
    bus.miss_detected     = 1'b1;
    bus.miss_address      = maddr;
    bus.memory_data_valid = 1'b0;
    if (with_store) begin
      bus.store_req  = 1'b1;
      bus.store_addr = 16'h0080;
      bus.store_data = 16'hC0DE;
    end
    @(negedge clk);
    check("miss_cycle_busy", bus.fsm_busy, 0);
    check("miss_cycle_no_req", bus.mem_enable, 0);
    check("miss_cycle_no_ack", bus.store_ack, 0);
    c = 1;
    while (!done && !aborted && c < 200) begin
      @(posedge clk); #1;
      bus.miss_detected = noise && ($urandom_range(0, 1) == 1);
      bus.miss_address  = 16'($urandom);
      vld = (due_q.size() > 0) && (due_q[0] == c);
      bus.memory_data_valid = vld;
      bus.memory_data       = vld ? dat_q[0] : 16'($urandom);
      if (vld) begin
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
      @(negedge clk);
      check("fill_busy", bus.fsm_busy, 1);
      check("fill_store_ack", bus.store_ack, 0);
      check("req_enable", bus.mem_enable, c <= WORDS_PER_BLOCK);
      if (c <= WORDS_PER_BLOCK) begin
        check("req_addr", bus.mem_addr, blk + 16'(2 * (c - 1)));
        check("req_wr", bus.mem_wr, 0);
      end
      check("data_wr", bus.write_data_array, vld);
      check("tag_wr", bus.write_tag_array, vld && (n_wr == WORDS_PER_BLOCK - 1));
      if (vld) begin
        check("fill_addr", bus.fill_addr, blk + 16'(2 * n_wr));
        check("fill_data", bus.fill_data, mem_fn(blk + 16'(2 * n_wr)));
        n_wr++;
      end
      if (bus.mem_enable && !bus.mem_wr) begin
        due = ((c + lat > last_due + 1) ? c + lat : last_due + 1) + $urandom_range(0, gap_max);
        due_q.push_back(due);
        dat_q.push_back(mem_fn(bus.mem_addr));
        last_due = due;
      end
      if (n_wr == WORDS_PER_BLOCK) done = 1;
      if (rst_after > 0 && n_wr == rst_after) begin
        rst = 1'b0;
        #1;
        outputs_quiet("reset_mid_fill");
        for (int i = 0; i < 6; i++) begin
          @(posedge clk); #1;
          if (i == 1) rst = 1'b1;
          bus.miss_detected     = 1'b0;
          bus.memory_data_valid = 1'b1;
          bus.memory_data       = 16'($urandom);
          @(negedge clk);
          outputs_quiet("late_valid");
        end
        bus.memory_data_valid = 1'b0;
        aborted = 1;
      end
      c++;
    end
    if (!aborted) begin
      if (!done) check("fill_timeout_words", n_wr, WORDS_PER_BLOCK);
      @(posedge clk); #1;
      bus.miss_detected     = 1'b0;
      bus.memory_data_valid = 1'b0;
      @(negedge clk);
      check("post_fill_busy", bus.fsm_busy, 0);
      check("post_fill_data_wr", bus.write_data_array, 0);
      check("post_fill_ack", bus.store_ack, with_store);
      if (with_store) begin
        check("held_store_addr", bus.mem_addr, 16'h0080);
        check("held_store_wr", bus.mem_wr, 1);
        check("held_store_data", bus.mem_data_in, 16'hC0DE);
        @(posedge clk); #1;
        bus.store_req = 1'b0;
      end
    end
  endtask

  initial begin
    seed = 16'($urandom);
    rst  = 1'b0;
    idle_inputs();
    #12;
    outputs_quiet("reset");
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b1;

    // Write-through store from IDLE
    @(posedge clk); #1;
    bus.store_req  = 1'b1;
    bus.store_addr = 16'h0040;
    bus.store_data = 16'hBEEF;
    @(negedge clk);
    check("store_ack", bus.store_ack, 1);
    check("store_en", bus.mem_enable, 1);
    check("store_wr", bus.mem_wr, 1);
    check("store_addr", bus.mem_addr, 16'h0040);
    check("store_data", bus.mem_data_in, 16'hBEEF);
    check("store_busy", bus.fsm_busy, 0);
    @(posedge clk); #1;
    bus.store_req = 1'b0;
    @(negedge clk);
    check("store_done_ack", bus.store_ack, 0);
    check("store_done_en", bus.mem_enable, 0);

    run_fill(16'h1236, 4, 0, 1'b0, 1'b0, 0);
    run_fill(16'h0010, 4, 0, 1'b1, 1'b0, 0);
    run_fill(16'($urandom), 1, 3, 1'b0, 1'b0, 0);
    run_fill(16'($urandom), 10, 3, 1'b0, 1'b0, 0);

    // Stray read data while idle must not touch the cache
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = 16'($urandom);
      @(negedge clk);
      outputs_quiet("idle_valid");
    end
    @(posedge clk); #1;
    bus.memory_data_valid = 1'b0;

    run_fill(16'h5A5A, 3, 2, 1'b0, 1'b1, 0);
    run_fill(16'hFFF2, 2, 1, 1'b0, 1'b0, 3);
    run_fill(16'hFFF0, 4, 1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      run_fill(16'($urandom), $urandom_range(1, 10), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Initiator side of the 16-bit, byte-addressed data memory port; it issues every request that the memory array answers.
- On a cache miss, it reads one 16-byte block (8 words) from memory and streams each returned word into the cache data array. It writes the tag on the last word.
- When idle, it also issues single-word write-through stores.
- Sits between the cache tag/data arrays and the memory model in the cachecpu memory stage.

Parameters:
- ADDR_WIDTH, 16, byte-address width.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; must be a power of 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- miss_detected  in  1  cache lookup missed this cycle.
- miss_address  in  ADDR_WIDTH  byte address of the missing access.
- store_req  in  1  write-through store pending; held until store_ack.
- store_addr  in  ADDR_WIDTH  store byte address (bit 0 = 0).
- store_data  in  16  store data.
- memory_data_valid  in  1  memory returns a read word this cycle.
- memory_data  in  16  returned read data.
- fsm_busy  out  1  controller not idle; pipeline must stall.
- store_ack  out  1  one-cycle pulse: store issued this cycle.
- mem_enable  out  1  memory request valid.
- mem_wr  out  1  1 = write, 0 = read; meaningful only with mem_enable.
- mem_addr  out  ADDR_WIDTH  request byte address.
- mem_data_in  out  16  write data to memory.
- write_data_array  out  1  write fill_data into the cache at fill_addr.
- write_tag_array  out  1  write the tag/valid for the block at fill_addr.
- fill_addr  out  ADDR_WIDTH  byte address of the word being filled.
- fill_data  out  16  word being filled (equals memory_data).

Behaviour:
- States: IDLE, FILL.
- Registers: base (block-aligned address), req_cnt, rsp_cnt, req_done; counters are log2(WORDS_PER_BLOCK) bits.
- Reset, asynchronous on rst=0:
  - state=IDLE; req_cnt=0, rsp_cnt=0, req_done=0, base=0.
  - All outputs 0 while in reset and in IDLE, except store_ack, mem_enable, mem_wr, mem_addr and mem_data_in, which are asserted only by the IDLE store path below.
- IDLE, miss_detected=1:
  - On the next edge, base <= miss_address with its low 4 bits cleared; counters cleared; state <= FILL.
  - No memory request is issued in this cycle.
- IDLE, store_req=1, miss_detected=0 (combinational outputs):
  - mem_enable=1, mem_wr=1, mem_addr=store_addr, mem_data_in=store_data, store_ack=1.
  - State stays IDLE.
- Miss has priority over a store in the same cycle; the store is held and acked after the fill completes.
- FILL, request side:
  - While req_done=0: mem_enable=1, mem_wr=0, mem_addr=base+2*req_cnt; req_cnt increments each cycle.
  - When req_cnt wraps from WORDS_PER_BLOCK-1, set req_done=1; mem_enable=0 from then on.
  - Requests occupy exactly WORDS_PER_BLOCK consecutive cycles.
- FILL, response side, each cycle with memory_data_valid=1:
  - write_data_array=1, fill_addr=base+2*rsp_cnt, fill_data=memory_data; rsp_cnt increments.
  - Responses are in order; latency is whatever the memory provides, and the controller counts valids, not cycles.
  - Requests and responses may overlap in the same cycle.
- Last word (memory_data_valid=1 and rsp_cnt=WORDS_PER_BLOCK-1):
  - write_tag_array=1 in the same cycle as the final write_data_array.
  - state <= IDLE; counters and req_done clear.
- fsm_busy = (state==FILL). It drops the cycle after write_tag_array.
- memory_data_valid in IDLE is ignored; no cache write occurs.
- miss_detected and store_req during FILL are ignored; base is latched once at entry.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; a block never crosses its 16-byte boundary.
- Reset mid-fill: immediate return to IDLE; the partial block is left without a tag write; late memory_data_valid pulses after reset are ignored.
- No store is ever issued while state==FILL.

Decomposition:
- Shared package cache_pkg:
  - state enum {IDLE, FILL}.
  - WORDS_PER_BLOCK.
  - BLOCK_OFFSET_BITS = log2(2*WORDS_PER_BLOCK) = 4.
  - WORD_BYTES = 2.
- One natural sub-module, block_word_counter: log2(WORDS_PER_BLOCK)-bit counter with inc, clr, async active-low rst, and a wrap output. It is instantiated twice (request and response).

Test Plan:
- Miss to 0x1236, memory latency 4:
  - mem_addr reads 0x1230, 0x1232 … 0x123E on cycles 1–8.
  - write_data_array on cycles 5–12, fill_addr 0x1230 … 0x123E.
  - write_tag_array only on cycle 12; fsm_busy high on cycles 1–12.
- Store 0x0040 ← 0xBEEF in IDLE: same cycle mem_enable=1, mem_wr=1, mem_addr=0x0040, mem_data_in=0xBEEF, store_ack=1; fsm_busy stays 0.
- Miss 0x0010 and store 0x0080 in the same cycle: no store_ack until the fill completes; store_ack in the first IDLE cycle after write_tag_array.
- Irregular latency (valid gaps of 0–3 cycles, latency 1 and latency 10): exactly 8 data writes with correct in-order addresses, and one tag write on the 8th.
- rst=0 asserted after the 3rd returned word of miss 0xFFF2: all outputs 0 immediately; no tag write; subsequent valids ignored; a new miss to 0xFFF0 fills 0xFFF0 … 0xFFFE with no wrap past 0xFFFF.
- memory_data_valid pulsed while IDLE, and miss_detected pulsed during FILL: no cache writes, and base is unchanged.
